// File: rtl/heartbeat_monitor.sv
// Multi-channel heartbeat period monitor with streak-filtered ok status and a fault interrupt.
// Define HB_FAULT_LATCH_EN to enable the write-1-to-clear fault_sticky latches.
module heartbeat_monitor #(
    parameter int CHANNELS = 4,
    parameter int PERIOD   = 50000,
    parameter int TOL      = 100,
    parameter int DET_CNT  = 8,
    parameter int CNT_W    = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] pwm,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic [CHANNELS-1:0] fault_clr,
    output logic [CHANNELS-1:0] ok,
    output logic                all_ok,
    output logic                fault_irq,
    output logic [CHANNELS-1:0] fault_sticky
);

    localparam int STK_W = $clog2(DET_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD + TOL);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(PERIOD - TOL);
    localparam logic [STK_W-1:0] STK_MAX = STK_W'(DET_CNT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [CHANNELS-1:0] sync1_reg;
    logic [CHANNELS-1:0] sync2_reg;
    logic [CHANNELS-1:0] rise_edge;
    logic [CHANNELS-1:0] ok_reg;
    logic [CHANNELS-1:0] ok_next;
    logic [CHANNELS-1:0] fall;
    logic                fault_irq_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pwm;
            sync2_reg <= sync1_reg;
        end
    end

    assign rise_edge = sync1_reg & ~sync2_reg;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [1:0]       state_reg;
            logic [1:0]       state_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [STK_W-1:0] good_reg;
            logic [STK_W-1:0] good_next;
            logic [STK_W-1:0] bad_reg;
            logic [STK_W-1:0] bad_next;
            logic             good_ev;
            logic             bad_ev;
            logic             ok_ch;

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                good_ev    = 1'b0;
                bad_ev     = 1'b0;
                if (!ch_en[gi]) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            state_next = ST_ARM;
                            cnt_next   = '0;
                        end
                        ST_ARM: begin
                            // The first edge only starts timing; there is no interval yet.
                            if (rise_edge[gi]) begin
                                state_next = ST_RUN;
                                cnt_next   = CNT_W'(1);
                            end
                        end
                        ST_RUN: begin
                            // An edge landing on the timeout count takes precedence and is good.
                            if (rise_edge[gi]) begin
                                cnt_next = CNT_W'(1);
                                if (cnt_reg >= CNT_MIN && cnt_reg <= CNT_MAX) begin
                                    good_ev = 1'b1;
                                end else begin
                                    bad_ev = 1'b1;
                                end
                            end else if (cnt_reg == CNT_MAX) begin
                                bad_ev   = 1'b1;
                                cnt_next = CNT_W'(1);
                            end else begin
                                cnt_next = cnt_reg + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            always_comb begin
                good_next = good_reg;
                bad_next  = bad_reg;
                if (!ch_en[gi]) begin
                    good_next = '0;
                    bad_next  = '0;
                end else if (good_ev) begin
                    good_next = (good_reg == STK_MAX) ? good_reg : good_reg + STK_W'(1);
                    bad_next  = '0;
                end else if (bad_ev) begin
                    bad_next  = (bad_reg == STK_MAX) ? bad_reg : bad_reg + STK_W'(1);
                    good_next = '0;
                end
            end

            always_comb begin
                ok_ch = ok_reg[gi];
                if (!ch_en[gi]) begin
                    ok_ch = 1'b1;
                end else if (good_reg == STK_MAX) begin
                    ok_ch = 1'b1;
                end else if (bad_reg == STK_MAX) begin
                    ok_ch = 1'b0;
                end
            end

            assign ok_next[gi] = ok_ch;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    good_reg  <= '0;
                    bad_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    good_reg  <= good_next;
                    bad_reg   <= bad_next;
                end
            end
        end
    endgenerate

    assign fall = ok_reg & ~ok_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_reg        <= '1;
            fault_irq_reg <= 1'b0;
        end else begin
            ok_reg        <= ok_next;
            fault_irq_reg <= |fall;
        end
    end

    assign ok        = ok_reg;
    assign all_ok    = &ok_reg;
    assign fault_irq = fault_irq_reg;

`ifdef HB_FAULT_LATCH_EN
    logic [CHANNELS-1:0] sticky_reg;

    // A new fault outranks a clear strobe arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= '0;
        end else begin
            sticky_reg <= (sticky_reg & ~fault_clr) | fall;
        end
    end

    assign fault_sticky = sticky_reg;
`else
    logic unused_clr;

    assign unused_clr   = &{1'b0, fault_clr};
    assign fault_sticky = '0;
`endif

endmodule
